// File: rtl/proj_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : proj_pkg                                               |
// | Description : Shared widths, counts and state encodings for the      |
// |               sorter / extender datapath.                            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package proj_pkg;

  // Number of smallest-signature indices handed from sorter to extender
  localparam int SORTER_EXTENDER_INDICES_COUNT = 8;
  // Width of one index
  localparam int INDICE_LEN                    = 16;
  // Width of the rank field; 2**SORTER_POSITION_LEN >= indices count
  localparam int SORTER_POSITION_LEN           = 3;

  // Extender stream state
  typedef enum logic {
    EXT_IDLE = 1'b0,
    EXT_SEND = 1'b1
  } extender_state_e;

endpackage : proj_pkg
`default_nettype wire

// File: rtl/proj_extender_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : proj_extender_buf                                      |
// | Description : K x INDICE_LEN capture register with load enable and   |
// |               a read mux addressed by rank.                          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module proj_extender_buf
  import proj_pkg::*;
#(
  parameter int INDICES_COUNT = SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN_P  = INDICE_LEN,
  parameter int POSITION_LEN  = SORTER_POSITION_LEN
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      load_i,
  input  logic [INDICES_COUNT-1:0][INDICE_LEN_P-1:0] data_i,
  input  logic [POSITION_LEN-1:0]                   rd_addr_i,
  output logic [INDICE_LEN_P-1:0]                   rd_data_o
);

  logic [INDICES_COUNT-1:0][INDICE_LEN_P-1:0] slot_q;

  // Capture every slot of the sorter result in one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (load_i) begin
      slot_q <= data_i;
    end
  end

  // Select the slot for the current rank; unreachable ranks read as zero
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < INDICES_COUNT; i++) begin
      if (rd_addr_i == POSITION_LEN'(i)) begin
        rd_data_o = slot_q[i];
      end
    end
  end

endmodule : proj_extender_buf
`default_nettype wire

// File: rtl/proj_extender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : proj_extender                                          |
// | Description : Captures the sorter's K smallest indices and streams   |
// |               them out one per valid/ready transfer with rank and    |
// |               last flag. Flags busy, done and dropped results.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module proj_extender
  import proj_pkg::*;
#(
  parameter int INDICES_COUNT = SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN_P  = INDICE_LEN,
  parameter int POSITION_LEN  = SORTER_POSITION_LEN
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [INDICES_COUNT-1:0][INDICE_LEN_P-1:0] in_smallest_idx,
  input  logic                                      in_sort_valid,
  output logic                                      out_busy,
  output logic [INDICE_LEN_P-1:0]                   out_index,
  output logic [POSITION_LEN-1:0]                   out_position,
  output logic                                      out_last,
  output logic                                      out_valid,
  input  logic                                      in_ready,
  output logic                                      out_done,
  output logic                                      out_drop
);

  // Rank of the final beat, compared at full counter width
  localparam logic [POSITION_LEN-1:0] LAST_POS = POSITION_LEN'(INDICES_COUNT - 1);

  extender_state_e           state_q,    state_d;
  logic [POSITION_LEN-1:0]   position_q, position_d;
  logic                      done_q,     done_d;
  logic                      drop_q,     drop_d;
  logic                      load;
  logic [INDICE_LEN_P-1:0]   rd_data;
  logic                      sending;

  proj_extender_buf #(
    .INDICES_COUNT (INDICES_COUNT),
    .INDICE_LEN_P  (INDICE_LEN_P),
    .POSITION_LEN  (POSITION_LEN)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .data_i    (in_smallest_idx),
    .rd_addr_i (position_q),
    .rd_data_o (rd_data)
  );

  // State, rank counter and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EXT_IDLE;
      position_q <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      position_q <= position_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state: capture in IDLE, advance rank on each accepted beat in SEND
  always_comb begin
    state_d    = state_q;
    position_d = position_q;
    done_d     = 1'b0;
    drop_d     = drop_q;
    load       = 1'b0;
    case (state_q)
      EXT_IDLE: begin
        if (in_sort_valid) begin
          load       = 1'b1;
          position_d = '0;
          state_d    = EXT_SEND;
        end
      end
      EXT_SEND: begin
        // A new result while draining is discarded but remembered
        if (in_sort_valid) begin
          drop_d = 1'b1;
        end
        if (in_ready) begin
          if (position_q == LAST_POS) begin
            state_d    = EXT_IDLE;
            position_d = '0;
            done_d     = 1'b1;
          end else begin
            position_d = position_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = EXT_IDLE;
        position_d = '0;
      end
    endcase
  end

  assign sending      = (state_q == EXT_SEND);
  assign out_valid    = sending;
  assign out_busy     = sending;
  assign out_index    = sending ? rd_data : '0;
  assign out_position = position_q;
  assign out_last     = sending && (position_q == LAST_POS);
  assign out_done     = done_q;
  assign out_drop     = drop_q;

endmodule : proj_extender
`default_nettype wire

// File: tb/tb_proj_extender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_proj_extender                                       |
// | Description : Scoreboard bench for proj_extender (K=8, 16-bit index). |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_proj_extender;

  localparam int K = 8;
  localparam int W = 16;
  localparam int P = 3;

  typedef struct packed {
    logic [W-1:0] idx;
    logic [P-1:0] pos;
    logic         last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [K-1:0][W-1:0] in_smallest_idx = '0;
  logic                in_sort_valid = 1'b0;
  logic                in_ready = 1'b0;
  logic                out_busy;
  logic [W-1:0]        out_index;
  logic [P-1:0]        out_position;
  logic                out_last;
  logic                out_valid;
  logic                out_done;
  logic                out_drop;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t e;

  logic         prev_stall = 1'b0;
  logic [W-1:0] p_idx;
  logic [P-1:0] p_pos;
  logic         p_last;

  proj_extender #(
    .INDICES_COUNT (K),
    .INDICE_LEN_P  (W),
    .POSITION_LEN  (P)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_smallest_idx (in_smallest_idx),
    .in_sort_valid   (in_sort_valid),
    .out_busy        (out_busy),
    .out_index       (out_index),
    .out_position    (out_position),
    .out_last        (out_last),
    .out_valid       (out_valid),
    .in_ready        (in_ready),
    .out_done        (out_done),
    .out_drop        (out_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Pop the scoreboard on every transfer; check stalled beats stay frozen
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        vectors++;
        if (out_valid !== 1'b1 || out_index !== p_idx || out_position !== p_pos || out_last !== p_last) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%0b idx=%h pos=%0d last=%0b, need v=1 idx=%h pos=%0d last=%0b",
                   out_valid, out_index, out_position, out_last, p_idx, p_pos, p_last);
        end
      end
      if (out_valid && in_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL beat_unexpected: got idx=%h pos=%0d, need no transfer", out_index, out_position);
        end else begin
          e = sb.pop_front();
          if (out_index !== e.idx || out_position !== e.pos || out_last !== e.last) begin
            miscompares++;
            $display("FAIL beat: got idx=%h pos=%0d last=%0b, need idx=%h pos=%0d last=%0b",
                     out_index, out_position, out_last, e.idx, e.pos, e.last);
          end
        end
      end
      prev_stall = out_valid && !in_ready;
      p_idx  = out_index;
      p_pos  = out_position;
      p_last = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load(input logic [W-1:0] base, input bit zero);
    exp_t x;
    @(posedge clk); #1;
    for (int k = 0; k < K; k++) begin
      in_smallest_idx[k] = zero ? '0 : base + W'(k);
      x.idx  = in_smallest_idx[k];
      x.pos  = P'(k);
      x.last = (k == K - 1);
      sb.push_back(x);
    end
    in_sort_valid = 1'b1;
    @(posedge clk); #1;
    in_sort_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_done) begin
        found  = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({out_valid, out_busy, out_done, out_drop, out_last} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got v/b/d/dr/l=%b, need 00000",
               {out_valid, out_busy, out_done, out_drop, out_last});
    end
    vectors++;
    if (out_index !== '0 || out_position !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got idx=%h pos=%0d, need 0/0", out_index, out_position);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_capture_drain();
    int busy_n = 0, valid_n = 0, done_n = 0, done_at = -1;
    in_ready = 1'b1;
    load(16'h0010, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_busy) busy_n++;
      if (out_valid) valid_n++;
      if (out_done) begin done_n++; done_at = i; end
    end
    vectors++;
    if (busy_n != 8) begin miscompares++; $display("FAIL drain_busy: got %0d cycles, need 8", busy_n); end
    vectors++;
    if (valid_n != 8) begin miscompares++; $display("FAIL drain_valid: got %0d cycles, need 8", valid_n); end
    vectors++;
    if (done_n != 1 || done_at != 8) begin
      miscompares++;
      $display("FAIL drain_done: got %0d pulses at cycle %0d, need 1 at cycle 8", done_n, done_at);
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL drain_left: got %0d pending, need 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int valid_n = 0, done_at = -1;
    load(16'h0010, 1'b0);
    for (int c = 0; c < 16; c++) begin
      in_ready = !(c inside {2, 3, 4, 8, 9, 10});
      @(negedge clk);
      if (out_valid) valid_n++;
      if (out_done) done_at = c;
      if (c inside {2, 3, 4, 8, 9, 10}) begin
        vectors++;
        if (out_valid !== 1'b1 || out_index !== ((c < 5) ? 16'h0012 : 16'h0015)) begin
          miscompares++;
          $display("FAIL stall_index c=%0d: got v=%0b idx=%h, need v=1 idx=%h",
                   c, out_valid, out_index, (c < 5) ? 16'h0012 : 16'h0015);
        end
      end
      @(posedge clk); #1;
    end
    in_ready = 1'b1;
    vectors++;
    if (valid_n != 14) begin miscompares++; $display("FAIL bp_valid: got %0d cycles, need 14", valid_n); end
    vectors++;
    if (done_at != 14) begin miscompares++; $display("FAIL bp_done: got cycle %0d, need 14", done_at); end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL bp_left: got %0d pending, need 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit   found = 1'b0;
    int   cyc;
    exp_t x;
    in_ready = 1'b1;
    load(16'h0040, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_done) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL b2b_first_done: got none, need a pulse"); end
    // New result presented during the done cycle
    for (int k = 0; k < K; k++) begin
      in_smallest_idx[k] = 16'h0100 + W'(k);
      x.idx  = in_smallest_idx[k];
      x.pos  = P'(k);
      x.last = (k == K - 1);
      sb.push_back(x);
    end
    in_sort_valid = 1'b1;
    @(posedge clk); #1;
    in_sort_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_index !== 16'h0100 || out_position !== '0) begin
      miscompares++;
      $display("FAIL b2b_resume: got v=%0b idx=%h pos=%0d, need v=1 idx=0100 pos=0",
               out_valid, out_index, out_position);
    end
    wait_done(20, found, cyc);
    vectors++;
    if (!found) begin miscompares++; $display("FAIL b2b_second_done: got none, need a pulse"); end
    vectors++;
    if (out_drop !== 1'b0) begin miscompares++; $display("FAIL b2b_drop: got %0b, need 0", out_drop); end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_left: got %0d pending, need 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int cyc, done_n = 0;
    in_ready = 1'b1;
    load(16'h0020, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_busy !== 1'b0 || out_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_state: got v=%0b b=%0b d=%0b, need 0/0/0", out_valid, out_busy, out_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_done) done_n++;
    end
    vectors++;
    if (done_n != 0) begin miscompares++; $display("FAIL rstmid_done: got %0d pulses, need 0", done_n); end
    sb.delete();
    load(16'h0030, 1'b0);
    wait_done(20, found, cyc);
    vectors++;
    if (!found || cyc != 8) begin
      miscompares++;
      $display("FAIL rstmid_reload: got found=%0b at %0d, need found=1 at 8", found, cyc);
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL rstmid_left: got %0d pending, need 0", sb.size()); end
  endtask

  task automatic test_placeholder();
    bit found;
    int cyc;
    in_ready = 1'b1;
    load(16'h0000, 1'b1);
    wait_done(20, found, cyc);
    vectors++;
    if (!found) begin miscompares++; $display("FAIL zero_done: got none, need a pulse"); end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL zero_left: got %0d pending, need 0", sb.size()); end
  endtask

  task automatic test_drop();
    int done_n = 0;
    in_ready = 1'b1;
    load(16'h0010, 1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin
        for (int k = 0; k < K; k++) in_smallest_idx[k] = 16'hAAAA;
        in_sort_valid = 1'b1;
      end else begin
        in_sort_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 3) begin
        vectors++;
        if (out_drop !== 1'b0) begin miscompares++; $display("FAIL drop_early: got %0b, need 0", out_drop); end
      end
      if (c == 4) begin
        vectors++;
        if (out_drop !== 1'b1) begin miscompares++; $display("FAIL drop_set: got %0b, need 1", out_drop); end
      end
      if (out_done) done_n++;
      @(posedge clk); #1;
    end
    in_sort_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (done_n != 1) begin miscompares++; $display("FAIL drop_done: got %0d pulses, need 1", done_n); end
    vectors++;
    if (out_drop !== 1'b1 || out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_sticky: got drop=%0b busy=%0b, need 1/0", out_drop, out_busy);
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL drop_left: got %0d pending, need 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_capture_drain();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_placeholder();
    test_drop();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_proj_extender
`default_nettype wire
